// File: rtl/kb_event_arbiter.sv
// kb_event_arbiter: merges matrix and injector key events through a
// round-robin grant, a small FIFO and a strobe-spacing sequencer.
module kb_event_arbiter #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   a_valid,
   input  logic [7:0]             a_code,
   input  logic                   a_ext,
   input  logic                   a_rls,
   output logic                   a_ready,
   input  logic                   b_valid,
   input  logic [7:0]             b_code,
   input  logic                   b_ext,
   input  logic                   b_rls,
   output logic                   b_ready,
   output logic                   scan_strobe,
   output logic [7:0]             scancode,
   output logic                   extended,
   output logic                   released,
   output logic                   pending,
   output logic                   backpressure,
   input  logic                   status_rd,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      GAP
   } seq_e;

   seq_e          state_q, state_d;
   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [LW-1:0] level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_b_q;
   logic [7:0]    code_q;
   logic          ext_q, rls_q;
   logic          strobe_q;
   logic          pend_q, pend_d;
   logic          bp_q, bp_d;
   logic          rd_q;
   logic          grant_a, grant_b;
   logic          full, push, pop, rd_end;
   logic [9:0]    wdata, head;

   // B served last means A wins a tie
   assign grant_a = a_valid & (~b_valid | last_b_q);
   assign grant_b = b_valid & ~grant_a;
   assign full    = (level_q == LW'(DEPTH));
   assign a_ready = grant_a & ~full;
   assign b_ready = grant_b & ~full;
   assign push    = a_ready | b_ready;
   assign wdata   = a_ready ? {a_code, a_ext, a_rls}
                            : {b_code, b_ext, b_rls};
   assign head    = mem_q[rptr_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            cnt_d   = CW'(GAP_CYCLES);
            state_d = GAP;
         end
         GAP: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // end of a CPU status read clears both flags; a same-edge set wins
   assign rd_end = rd_q & ~status_rd;
   assign pend_d = strobe_q | (pend_q & ~rd_end);
   assign bp_d   = ((a_valid | b_valid) & full) | (bp_q & ~rd_end);

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         last_b_q <= 1'b1;
         code_q   <= '0;
         ext_q    <= 1'b0;
         rls_q    <= 1'b0;
         strobe_q <= 1'b0;
         pend_q   <= 1'b0;
         bp_q     <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         strobe_q <= (state_q == EMIT);
         pend_q   <= pend_d;
         bp_q     <= bp_d;
         rd_q     <= status_rd;
         if (push) begin
            wptr_q   <= wptr_q + AW'(1);
            last_b_q <= b_ready;
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
            code_q <= head[9:2];
            ext_q  <= head[1];
            rls_q  <= head[0];
         end
      end
   end

   assign scan_strobe  = strobe_q;
   assign scancode     = code_q;
   assign extended     = ext_q;
   assign released     = rls_q;
   assign pending      = pend_q;
   assign backpressure = bp_q;
   assign fifo_level   = level_q;

endmodule

// File: tb/tb_kb_event_arbiter.sv
// Directed bench for kb_event_arbiter: grant order, strobe timing,
// FIFO fill/wrap, pending/backpressure flags and mid-run reset.
module tb_kb_event_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, a_ext, a_rls, a_ready;
   logic       b_valid, b_ext, b_rls, b_ready;
   logic [7:0] a_code, b_code;
   logic       scan_strobe, extended, released;
   logic [7:0] scancode;
   logic       pending, backpressure, status_rd;
   logic [3:0] fifo_level;

   int n_cmp = 0;
   int n_err = 0;

   kb_event_arbiter #(.DEPTH(8), .GAP_CYCLES(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_valid      (a_valid),
      .a_code       (a_code),
      .a_ext        (a_ext),
      .a_rls        (a_rls),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_code       (b_code),
      .b_ext        (b_ext),
      .b_rls        (b_rls),
      .b_ready      (b_ready),
      .scan_strobe  (scan_strobe),
      .scancode     (scancode),
      .extended     (extended),
      .released     (released),
      .pending      (pending),
      .backpressure (backpressure),
      .status_rd    (status_rd),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      a_valid   = 1'b0;
      a_code    = 8'h00;
      a_ext     = 1'b0;
      a_rls     = 1'b0;
      b_valid   = 1'b0;
      b_code    = 8'h00;
      b_ext     = 1'b0;
      b_rls     = 1'b0;
      status_rd = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [7:0]  codes [20] = '{
      8'h12, 8'h1C, 8'h23, 8'h2B, 8'h34,
      8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C,
      8'h52, 8'h5A, 8'h66, 8'h76, 8'h0D,
      8'h14, 8'h11, 8'h1F, 8'h27, 8'h2F};
   logic [19:0] ext_m = 20'h5A3C5;
   logic [19:0] rls_m = 20'h3C96B;
   logic [31:0] vpat  = 32'hB3A5_96C7;

   initial begin : main
      int         got, prev, in_i, out_i, strobes;
      logic       acc, hold, saw_full, ready_low;
      logic [7:0] nxt;
      logic [7:0] exp_code [4];

      // reset state
      do_reset;
      rst_n = 1'b0;
      #2;
      check("rst_strobe", 32'(scan_strobe), 0);
      check("rst_code", 32'(scancode), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_level", 32'(fifo_level), 0);
      do_reset;

      // single event
      a_valid = 1'b1;
      a_code  = 8'h1C;
      #1;
      check("single_ready", 32'(a_ready), 1);
      tick;
      a_valid = 1'b0;
      check("single_level", 32'(fifo_level), 1);
      tick;
      check("single_nostrobe", 32'(scan_strobe), 0);
      tick;
      check("single_strobe", 32'(scan_strobe), 1);
      check("single_code", 32'(scancode), 32'h1C);
      check("single_flags", 32'({extended, released}), 0);
      tick;
      check("single_strobe_off", 32'(scan_strobe), 0);
      check("single_pending", 32'(pending), 1);
      status_rd = 1'b1;
      repeat (3) tick;
      status_rd = 1'b0;
      check("rd_hold", 32'(pending), 1);
      tick;
      check("rd_clear", 32'(pending), 0);

      // tie fairness and strobe spacing
      do_reset;
      a_valid = 1'b1;
      a_code  = 8'h10;
      b_valid = 1'b1;
      b_code  = 8'h20;
      exp_code = '{8'h10, 8'h20, 8'h10, 8'h20};
      got  = 0;
      prev = 0;
      for (int c = 0; c < 120 && got < 4; c++) begin
         #1;
         if (c < 4)
            check("tie_grant", 32'({a_ready, b_ready}),
                  (c % 2 == 0) ? 32'h2 : 32'h1);
         tick;
         if (scan_strobe) begin
            check("tie_code", 32'(scancode), 32'(exp_code[got]));
            if (got == 0) check("tie_latency", c, 2);
            else check("tie_spacing", c - prev, 18);
            prev = c;
            got++;
         end
      end
      check("tie_count", got, 4);
      check("tie_bp", 32'(backpressure), 1);

      // full FIFO, contiguous output
      do_reset;
      nxt       = 8'h00;
      got       = 0;
      saw_full  = 1'b0;
      ready_low = 1'b0;
      a_valid   = 1'b1;
      for (int c = 0; c < 400 && got < 10; c++) begin
         a_code = nxt;
         #1;
         acc = a_ready;
         tick;
         if (acc) nxt++;
         if (fifo_level == 4'd8) begin
            saw_full = 1'b1;
            if (!a_ready) ready_low = 1'b1;
         end
         if (scan_strobe) begin
            check("full_seq", 32'(scancode), got);
            got++;
         end
      end
      a_valid = 1'b0;
      check("full_count", got, 10);
      check("full_level8", 32'(saw_full), 1);
      check("full_ready_low", 32'(ready_low), 1);
      check("full_bp", 32'(backpressure), 1);

      // pointer wrap with gaps in valid
      do_reset;
      in_i  = 0;
      out_i = 0;
      hold  = 1'b0;
      for (int c = 0; c < 700 && out_i < 20; c++) begin
         if (!hold && in_i < 20 && vpat[c % 32]) hold = 1'b1;
         a_valid = hold;
         if (in_i < 20) begin
            a_code = codes[in_i];
            a_ext  = ext_m[in_i];
            a_rls  = rls_m[in_i];
         end
         #1;
         acc = a_valid & a_ready;
         tick;
         if (acc) begin
            in_i++;
            hold = 1'b0;
         end
         if (scan_strobe) begin
            check("wrap_ev",
                  32'({scancode, extended, released}),
                  32'({codes[out_i], ext_m[out_i], rls_m[out_i]}));
            out_i++;
         end
      end
      a_valid = 1'b0;
      check("wrap_count", out_i, 20);

      // status read ends on the strobe cycle: set wins
      do_reset;
      a_valid = 1'b1;
      a_code  = 8'h31;
      tick;
      a_code = 8'h32;
      tick;
      a_valid = 1'b0;
      repeat (16) tick;
      status_rd = 1'b1;
      repeat (3) tick;
      status_rd = 1'b0;
      check("sc_strobe", 32'(scan_strobe), 1);
      check("sc_code", 32'(scancode), 32'h32);
      check("sc_pend_before", 32'(pending), 1);
      tick;
      check("sc_pend_after", 32'(pending), 1);

      // reset during GAP with entries queued
      do_reset;
      a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_code = 8'h41 + 8'(i);
         tick;
      end
      a_valid = 1'b0;
      repeat (2) tick;
      check("mr_level_pre", 32'(fifo_level), 3);
      check("mr_code_pre", 32'(scancode), 32'h41);
      rst_n = 1'b0;
      #1;
      check("mr_strobe", 32'(scan_strobe), 0);
      check("mr_code", 32'(scancode), 0);
      check("mr_pending", 32'(pending), 0);
      check("mr_level", 32'(fifo_level), 0);
      check("mr_ready", 32'({a_ready, b_ready}), 0);
      #3;
      rst_n   = 1'b1;
      strobes = 0;
      for (int c = 0; c < 40; c++) begin
         tick;
         if (scan_strobe) strobes++;
      end
      check("mr_no_strobe", strobes, 0);
      check("mr_level_post", 32'(fifo_level), 0);
      a_valid = 1'b1;
      a_code  = 8'h55;
      tick;
      a_valid = 1'b0;
      repeat (2) tick;
      check("mr_new_strobe", 32'(scan_strobe), 1);
      check("mr_new_code", 32'(scancode), 32'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
